// File: rtl/posit_add_sched_es3.sv
// ---------------------------------------------------------------------------
// posit_add_sched_es3
//   Round-robin scheduler that shares one external LATENCY-stage posit adder
//   (32-bit, es=3) among NREQ requesters. At most one operand pair is issued
//   per cycle. The requester ID travels down a tag pipe that matches the adder
//   latency, and each result goes back to its owner on a registered response
//   port.
//
//   Optional build macro: POSIT_ADD_SCHED_STATS_EN adds per-requester
//   grant/stall counters (stat_sel, stat_grants, stat_stalls).
//
// Ports
//   clk, reset              clock (rising edge), synchronous active-high reset
//   req_valid/req_ready     per-requester handshake; req_ready is a one-hot grant
//   req_in1/req_in2         packed operands, requester i at [32i+31:32i]
//   add_in1/add_in2/add_start  issue side of the adder
//   add_result/add_inf/add_zero/add_done  completion side of the adder
//   rsp_valid/rsp_id/rsp_result/rsp_inf/rsp_zero  registered response
//   busy                    any tag in flight or any response pending
//   err                     sticky: add_done disagreed with the expected tag
// ---------------------------------------------------------------------------
module posit_add_sched_es3 #(
  parameter  int NREQ    = 4,
  parameter  int LATENCY = 4,
  parameter  int MAX_OUT = 4,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_in1,
  input  logic [NREQ*32-1:0]   req_in2,
  output logic [31:0]          add_in1,
  output logic [31:0]          add_in2,
  output logic                 add_start,
  input  logic [31:0]          add_result,
  input  logic                 add_inf,
  input  logic                 add_zero,
  input  logic                 add_done,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_inf,
  output logic                 rsp_zero,
  output logic                 busy,
  output logic                 err
`ifdef POSIT_ADD_SCHED_STATS_EN
  ,
  input  logic [IDW-1:0]       stat_sel,
  output logic [15:0]          stat_grants,
  output logic [15:0]          stat_stalls
`endif
);

  localparam int CW = $clog2(MAX_OUT + 1);   // in-flight counter width
  localparam int FW = $clog2(LATENCY + 1);   // flush-window counter width

  logic [IDW-1:0]     rr_ptr;
  logic [CW-1:0]      out_cnt [NREQ];
  logic [LATENCY-1:0] tag_v;
  logic [IDW-1:0]     tag_id  [LATENCY];
  logic [FW-1:0]      flush_cnt;

  logic [NREQ-1:0]    eligible;
  logic               grant_valid;
  logic [IDW-1:0]     grant_id;
  logic               last_v;
  logic [IDW-1:0]     last_id;

  assign last_v  = tag_v[LATENCY-1];
  assign last_id = tag_id[LATENCY-1];

  // A requester at its in-flight limit is simply masked; others still issue.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (out_cnt[i] < CW'(MAX_OUT));
    end
  end

  // First eligible index at or after rr_ptr, wrapping modulo NREQ.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    if (!reset) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!grant_valid && eligible[(int'(rr_ptr) + k) % NREQ]) begin
          grant_valid = 1'b1;
          grant_id    = IDW'((int'(rr_ptr) + k) % NREQ);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    add_in1   = '0;
    add_in2   = '0;
    add_start = grant_valid;
    if (grant_valid) begin
      req_ready[grant_id] = 1'b1;
      add_in1 = req_in1[int'(grant_id)*32 +: 32];
      add_in2 = req_in2[int'(grant_id)*32 +: 32];
    end
  end

  assign busy = (|tag_v) || (|rsp_valid);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others (no order dependence).
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      tag_v      <= '0;
      rsp_valid  <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_inf    <= 1'b0;
      rsp_zero   <= 1'b0;
      err        <= 1'b0;
      // The adder keeps running through reset; its stale done pulses land
      // while all tags are empty, so err checking waits out one latency.
      flush_cnt  <= FW'(LATENCY);
      for (int i = 0; i < NREQ; i++) begin
        out_cnt[i] <= '0;
      end
    end else begin
      if (grant_valid) begin
        rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end

      tag_v[0] <= grant_valid;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v[k] <= tag_v[k-1];
      end

      // Response follows the tag; add_done only feeds the consistency check.
      rsp_valid <= '0;
      if (last_v) begin
        rsp_valid[last_id] <= 1'b1;
        rsp_id             <= last_id;
        rsp_result         <= add_result;
        rsp_inf            <= add_inf;
        rsp_zero           <= add_zero;
      end

      for (int i = 0; i < NREQ; i++) begin
        if ((grant_valid && grant_id == IDW'(i)) && !(last_v && last_id == IDW'(i))) begin
          out_cnt[i] <= out_cnt[i] + 1'b1;
        end else if (!(grant_valid && grant_id == IDW'(i)) && (last_v && last_id == IDW'(i))) begin
          out_cnt[i] <= out_cnt[i] - 1'b1;
        end
      end

      if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 1'b1;
      end else if (add_done != last_v) begin
        err <= 1'b1;
      end
    end
  end

  // NOTE: tag IDs are always qualified by tag_v, so they carry no reset and
  // stay plain shift registers.
  always_ff @(posedge clk) begin
    tag_id[0] <= grant_id;
    for (int k = 1; k < LATENCY; k++) begin
      tag_id[k] <= tag_id[k-1];
    end
  end

`ifdef POSIT_ADD_SCHED_STATS_EN
  logic [15:0] st_grants [NREQ];
  logic [15:0] st_stalls [NREQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants <= '0;
      stat_stalls <= '0;
      for (int i = 0; i < NREQ; i++) begin
        st_grants[i] <= '0;
        st_stalls[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i] && st_grants[i] != 16'hFFFF) begin
          st_grants[i] <= st_grants[i] + 16'd1;
        end
        if (req_valid[i] && !req_ready[i] && st_stalls[i] != 16'hFFFF) begin
          st_stalls[i] <= st_stalls[i] + 16'd1;
        end
      end
      // stat_sel may name a nonexistent requester when NREQ is not a power of two.
      if (int'(stat_sel) < NREQ) begin
        stat_grants <= st_grants[stat_sel];
        stat_stalls <= st_stalls[stat_sel];
      end else begin
        stat_grants <= '0;
        stat_stalls <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_posit_add_sched_es3.sv
// ---------------------------------------------------------------------------
// tb_posit_add_sched_es3
//   Directed bench for posit_add_sched_es3. A behavioural 4-stage stand-in
//   adder (no reset) sits on the adder ports. Each observed grant pushes the
//   expected response (owner, stand-in sum, due cycle) onto a scoreboard
//   queue, and each rsp_valid pops and compares it.
// ---------------------------------------------------------------------------
module tb_posit_add_sched_es3;

  localparam int NREQ    = 4;
  localparam int LATENCY = 4;
  localparam int MAX_OUT = 4;
  localparam int IDW     = 2;

  localparam logic [31:0] NAR = 32'h8000_0000;
  localparam logic [31:0] ONE = 32'h4000_0000;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_in1, req_in2;
  logic [31:0]         add_in1, add_in2;
  logic                add_start;
  logic [31:0]         add_result;
  logic                add_inf, add_zero, add_done;
  logic [NREQ-1:0]     rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_result;
  logic                rsp_inf, rsp_zero, busy, err;

  logic [31:0] op1 [NREQ];
  logic [31:0] op2 [NREQ];
  logic        force_done = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_in1[i*32 +: 32] = op1[i];
      req_in2[i*32 +: 32] = op2[i];
    end
  end

  posit_add_sched_es3 #(.NREQ(NREQ), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
    .busy(busy), .err(err)
  );

  // Stand-in posit adder: exact for NaR, exact cancellation and 1.0+1.0,
  // otherwise an arbitrary deterministic mix. Returns {inf, zero, result}.
  function automatic logic [33:0] stub_add(input logic [31:0] a, input logic [31:0] b);
    if (a == NAR || b == NAR) return {2'b10, NAR};
    if (a + b == 32'h0)       return {2'b01, 32'h0};
    if (a == ONE && b == ONE) return {2'b00, 32'h4400_0000};
    return {2'b00, a ^ {b[15:0], b[31:16]} ^ 32'h1};
  endfunction

  logic [3:0]  ap_v = '0;
  logic [33:0] ap_d [4];
  always @(posedge clk) begin
    ap_v  <= {ap_v[2:0], add_start};
    ap_d[0] <= stub_add(add_in1, add_in2);
    for (int k = 1; k < 4; k++) ap_d[k] <= ap_d[k-1];
  end
  assign add_done = ap_v[3] | force_done;
  assign {add_inf, add_zero, add_result} = ap_d[3];

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    res;
    logic           inf;
    logic           zero;
    int             due;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;
  int   last_grant = -1;
  int   n_rsp = 0;
  logic [31:0] last_res;
  logic        last_inf, last_zero;
  logic [IDW-1:0] last_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic new_ops(input int g);
    op1[g] = $urandom;
    op2[g] = $urandom;
  endtask

  // One clock cycle: called just after a negedge with inputs already driven.
  task automatic tick();
    int g;
    exp_t e;
    logic [33:0] s;
    #2;
    last_grant = -1;
    if (add_start) begin
      check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
      g = 0;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
      check("grant_has_valid", 32'(req_valid[g]), 32'd1);
      check("add_in1", add_in1, op1[g]);
      check("add_in2", add_in2, op2[g]);
      s = stub_add(op1[g], op2[g]);
      e.id = IDW'(g); e.inf = s[33]; e.zero = s[32]; e.res = s[31:0];
      e.due = cyc + LATENCY + 1;
      sb.push_back(e);
      grant_log.push_back(g);
      last_grant = g;
    end else begin
      check("ready_idle", 32'(req_ready), 32'd0);
    end
    if (!reset) begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_result", rsp_result, e.res);
          check("rsp_inf", 32'(rsp_inf), 32'(e.inf));
          check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          check("rsp_cycle", 32'(cyc), 32'(e.due));
          last_res = rsp_result; last_inf = rsp_inf; last_zero = rsp_zero; last_id = rsp_id;
          n_rsp++;
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        check("rsp_missing", 32'(rsp_valid), 32'(1) << sb[0].id);
        void'(sb.pop_front());
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    sb.delete();
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    repeat (n) tick();
  endtask

  initial begin
    int cnt;
    int base;
    logic [31:0] pattern;
    for (int i = 0; i < NREQ; i++) begin op1[i] = '0; op2[i] = '0; end
    @(negedge clk);

    // Reset with everyone requesting: nothing may be granted.
    req_valid = '1;
    do_reset(3);
    req_valid = '0;
    #2;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk); cyc++;

    // Single op: 1.0 + 1.0 = 2.0, response five cycles after grant.
    op1[0] = ONE; op2[0] = ONE;
    req_valid = 4'b0001;
    base = n_rsp;
    tick();
    check("single_grant", 32'(last_grant), 32'd0);
    req_valid = '0;
    tick();
    check("single_busy", 32'(busy), 32'd1);
    drain(6);
    check("single_rsp_count", 32'(n_rsp - base), 32'd1);
    check("single_result", last_res, 32'h4400_0000);
    check("single_zero", 32'(last_zero), 32'd0);
    check("single_id", 32'(last_id), 32'd0);
    check("single_idle_busy", 32'(busy), 32'd0);

    // All four valid for 8 cycles: round-robin 0,1,2,3,0,1,2,3.
    do_reset(1);
    for (int i = 0; i < NREQ; i++) new_ops(i);
    grant_log.delete();
    req_valid = '1;
    repeat (8) begin
      tick();
      if (last_grant >= 0) new_ops(last_grant);
    end
    drain(8);
    check("rr_grant_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
      check($sformatf("rr_grant_%0d", k), 32'(grant_log[k]), 32'(k % NREQ));
    end
    check("rr_sb_empty", 32'(sb.size()), 32'd0);

    // Req2 alone: four grants, one gap until the first response, repeat.
    do_reset(1);
    pattern = '0;
    new_ops(2);
    req_valid = 4'b0100;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (last_grant == 2) begin
        pattern[k] = 1'b1;
        new_ops(2);
      end
    end
    drain(8);
    check("maxout_pattern", pattern, 32'b11110111101111);
    check("maxout_sb_empty", 32'(sb.size()), 32'd0);

    // Cancellation to zero, then NaR propagation.
    op1[1] = ONE; op2[1] = 32'hC000_0000;
    req_valid = 4'b0010;
    tick();
    drain(7);
    check("cancel_zero", 32'(last_zero), 32'd1);
    check("cancel_result", last_res, 32'h0);
    check("cancel_inf", 32'(last_inf), 32'd0);
    op1[1] = NAR; op2[1] = ONE;
    req_valid = 4'b0010;
    tick();
    drain(7);
    check("nar_inf", 32'(last_inf), 32'd1);
    check("nar_result", last_res, NAR);
    check("nar_id", 32'(last_id), 32'd1);

    // Reset with three ops in flight: none delivered, err stays clear.
    do_reset(1);
    new_ops(3);
    req_valid = 4'b1000;
    repeat (3) begin
      tick();
      if (last_grant == 3) new_ops(3);
    end
    check("flight_sb_size", 32'(sb.size()), 32'd3);
    req_valid = '0;
    do_reset(1);
    drain(10);
    check("flight_err", 32'(err), 32'd0);
    check("flight_busy", 32'(busy), 32'd0);
    // Counters must be back at zero: MAX_OUT back-to-back grants again.
    cnt = 0;
    req_valid = 4'b1000;
    repeat (5) begin
      tick();
      if (last_grant == 3) begin cnt++; new_ops(3); end
    end
    drain(8);
    check("flight_regrant", 32'(cnt), 32'(MAX_OUT));
    check("flight_err_after", 32'(err), 32'd0);

    // Spurious add_done with no tag: sticky err until reset.
    check("force_err_before", 32'(err), 32'd0);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    check("force_err_set", 32'(err), 32'd1);
    drain(5);
    check("force_err_held", 32'(err), 32'd1);
    do_reset(1);
    check("force_err_cleared", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
